// File: rtl/mcu_bus_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mcu_bus_pkg
//  Description : Shared types and constants for the MCU memory bus initiator
//                and its responders. Holds the access FSM state encoding,
//                address-space selector values, the SFR window base and the
//                wait-state limit, plus a helper sizing the wait counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mcu_bus_pkg;

  // Access sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_ERR    = 3'd4
  } state_t;

  // Value of memory_select / req_space for each address space.
  localparam logic SPACE_ROM = 1'b0;
  localparam logic SPACE_RAM = 1'b1;

  // Internal RAM / SFR split; decoded by the responder, not the initiator.
  localparam logic [7:0] SFR_BASE = 8'h80;

  // Largest supported number of extra strobe cycles.
  localparam int MAX_WAIT_STATES = 15;

  // Wait counter width: enough bits to hold ws, never narrower than 1.
  function automatic int wait_cnt_width(input int ws);
    return (ws < 1) ? 1 : $clog2(ws + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mcu_bus_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : mcu_bus_master_if
//  Description : Core-side request/response channel of the bus initiator.
//                The bus-initiator block takes the 'master' modport (it
//                masters the memory bus on the core's behalf); the CPU core
//                takes the 'core' modport.
//  Signals     : req_valid/req_ready handshake, req_write, req_space,
//                req_addr[ADDR_W], req_wdata[8];
//                rsp_valid pulse, rsp_err, rsp_rdata[8].
//  Revision    : 1.0 - initial release
// ============================================================================
interface mcu_bus_master_if #(
  parameter int ADDR_W = 16
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_space;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_wdata;
  logic              rsp_valid;
  logic              rsp_err;
  logic [7:0]        rsp_rdata;

  modport master (
    input  req_valid, req_write, req_space, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport core (
    output req_valid, req_write, req_space, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata
  );

endinterface
`default_nettype wire

// File: rtl/mcu_bus_master.sv
`default_nettype none
// ============================================================================
//  Module      : mcu_bus_master
//  Description : CPU-side initiator for the shared 16-bit address / 8-bit
//                data memory bus. Each accepted single-beat request runs as
//                SETUP -> STROBE (WAIT_STATES+1 cycles) -> HOLD, and read
//                data is returned on a one-cycle response pulse. Writes to
//                ROM space are rejected with a one-cycle error response.
//  Ports       : clk, reset (synchronous, active-low)
//                core          - request/response channel (master modport)
//                addr_bus      - bus address
//                data_bus      - bidirectional data, driven only during write
//                read_en       - read strobe
//                write_en      - write strobe
//                memory_select - 1 = RAM/SFR, 0 = ROM
//  Revision    : 1.0 - initial release
// ============================================================================
module mcu_bus_master
  import mcu_bus_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  mcu_bus_master_if.master        core,
  output logic [ADDR_W-1:0]       addr_bus,
  inout  wire  [7:0]              data_bus,
  output logic                    read_en,
  output logic                    write_en,
  output logic                    memory_select
);

  // Out-of-range settings are clamped to the longest supported strobe.
  localparam int c_wait  = (WAIT_STATES > MAX_WAIT_STATES) ? MAX_WAIT_STATES : WAIT_STATES;
  localparam int c_cnt_w = wait_cnt_width(c_wait);
  localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(c_wait);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  state_t              r_state;
  state_t              w_state_next;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_space;
  logic                r_write;
  logic [7:0]          r_wdata;
  logic [7:0]          r_rdata;

  logic w_ready;
  logic w_accept;
  logic w_reject;
  logic w_strobe;
  logic w_last_strobe;

  assign w_accept      = core.req_valid && w_ready;
  assign w_reject      = core.req_write && (core.req_space == SPACE_ROM);
  assign w_strobe      = (r_state == ST_STROBE);
  assign w_last_strobe = w_strobe && (r_cnt == '0);

  // Next state and all state-decoded outputs.
  always_comb begin
    w_state_next   = r_state;
    w_ready        = 1'b0;
    core.rsp_valid = 1'b0;
    core.rsp_err   = 1'b0;
    read_en        = 1'b0;
    write_en       = 1'b0;
    case (r_state)
      ST_IDLE, ST_HOLD, ST_ERR: begin
        w_ready        = 1'b1;
        core.rsp_valid = (r_state != ST_IDLE);
        core.rsp_err   = (r_state == ST_ERR);
        if (w_accept) begin
          w_state_next = w_reject ? ST_ERR : ST_SETUP;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_SETUP: begin
        w_state_next = ST_STROBE;
      end
      ST_STROBE: begin
        read_en  = ~r_write;
        write_en = r_write;
        if (r_cnt == '0) begin
          w_state_next = ST_HOLD;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_space <= SPACE_ROM;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_next;

      if (w_accept) begin
        r_write <= core.req_write;
        r_wdata <= core.req_wdata;
        // A rejected write never reaches the bus, so the address and
        // space shown to the responder keep their previous values.
        if (!w_reject) begin
          r_addr  <= core.req_addr;
          r_space <= core.req_space;
        end
      end

      if (r_state == ST_SETUP) begin
        r_cnt <= c_cnt_load;
      end else if (w_strobe && (r_cnt != '0)) begin
        r_cnt <= r_cnt - c_cnt_one;
      end

      // Read data is captured on the edge that ends the final strobe cycle.
      if (w_last_strobe && !r_write) begin
        r_rdata <= data_bus;
      end
    end
  end

  assign core.req_ready = w_ready;
  assign core.rsp_rdata = r_rdata;
  assign addr_bus       = r_addr;
  assign memory_select  = r_space;
  assign data_bus       = write_en ? r_wdata : 8'bzzzz_zzzz;

endmodule
`default_nettype wire

// File: tb/tb_mcu_bus_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mcu_bus_master
//  Description : Scoreboard bench for mcu_bus_master. Two instances: one
//                with WAIT_STATES = 1 and one with WAIT_STATES = 0. Stimulus
//                pushes expected responses (error flag, read data, cycle of
//                arrival) into per-instance queues; monitors pop and compare
//                whenever rsp_valid is seen. A bus keeper drives data_bus
//                whenever write_en is low, standing in for the responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mcu_bus_master;
  import mcu_bus_pkg::*;

  localparam int AW  = 16;
  localparam int WS1 = 1;

  typedef struct {
    logic       err;
    logic [7:0] rdata;
    int         cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t q1[$];
  exp_t q0[$];

  // model of what the WAIT_STATES = 1 instance should present
  logic [AW-1:0] m_addr1  = '0;
  logic          m_space1 = 1'b0;
  logic [7:0]    m_rdata1 = 8'h00;

  mcu_bus_master_if #(.ADDR_W(AW)) bus1 ();
  mcu_bus_master_if #(.ADDR_W(AW)) bus0 ();

  wire  [7:0]    data1;
  wire  [7:0]    data0;
  logic [AW-1:0] addr1, addr0;
  logic          rd1, wr1, ms1, rd0, wr0, ms0;
  logic [7:0]    keep1 = 8'hC3;
  logic [7:0]    keep0 = 8'hC3;

  assign data1 = wr1 ? 8'bzzzz_zzzz : keep1;
  assign data0 = wr0 ? 8'bzzzz_zzzz : keep0;

  mcu_bus_master #(.WAIT_STATES(WS1), .ADDR_W(AW)) dut1 (
    .clk(clk), .reset(reset), .core(bus1.master),
    .addr_bus(addr1), .data_bus(data1),
    .read_en(rd1), .write_en(wr1), .memory_select(ms1)
  );

  mcu_bus_master #(.WAIT_STATES(0), .ADDR_W(AW)) dut0 (
    .clk(clk), .reset(reset), .core(bus0.master),
    .addr_bus(addr0), .data_bus(data0),
    .read_en(rd0), .write_en(wr0), .memory_select(ms0)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- response monitors ----------------
  always @(negedge clk) begin
    exp_t e;
    check("strobe_exclusive", int'(rd1 && wr1), 0);
    if (bus1.rsp_valid) begin
      if (q1.size() == 0) begin
        check("rsp1_unexpected", 1, 0);
      end else begin
        e = q1.pop_front();
        check("rsp1_cycle", cyc, e.cyc);
        check("rsp1_err",   int'(bus1.rsp_err), int'(e.err));
        check("rsp1_rdata", int'(bus1.rsp_rdata), int'(e.rdata));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus0.rsp_valid) begin
      if (q0.size() == 0) begin
        check("rsp0_unexpected", 1, 0);
      end else begin
        e = q0.pop_front();
        check("rsp0_cycle", cyc, e.cyc);
        check("rsp0_err",   int'(bus0.rsp_err), int'(e.err));
        check("rsp0_rdata", int'(bus0.rsp_rdata), int'(e.rdata));
      end
    end
  end

  // ---------------- stimulus for the WAIT_STATES = 1 instance ----------------
  // Called on a negedge. Returns on the negedge of the response cycle, with
  // req_valid still high when hold = 1 so a follow-on request can be chained.
  task automatic issue1(input logic wr, input logic sp, input logic [AW-1:0] a,
                        input logic [7:0] wd, input logic [7:0] rv, input logic hold);
    exp_t e;
    int   k;
    logic err;
    logic strobe;
    err = wr && (sp == SPACE_ROM);
    bus1.req_valid = 1'b1;
    bus1.req_write = wr;
    bus1.req_space = sp;
    bus1.req_addr  = a;
    bus1.req_wdata = wd;
    keep1 = wr ? 8'hC3 : rv;
    k = 0;
    while (!bus1.req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!bus1.req_ready) begin
      check("req1_accept_timeout", 0, 1);
      bus1.req_valid = 1'b0;
      return;
    end
    if (!wr) m_rdata1 = rv;
    e.err   = err;
    e.rdata = m_rdata1;
    e.cyc   = cyc + (err ? 1 : 3 + WS1);
    q1.push_back(e);
    @(negedge clk);
    if (!hold) bus1.req_valid = 1'b0;
    if (err) begin
      check("err_addr_kept",  int'(addr1), int'(m_addr1));
      check("err_msel_kept",  int'(ms1), int'(m_space1));
      check("err_read_en",    int'(rd1), 0);
      check("err_write_en",   int'(wr1), 0);
      return;
    end
    m_addr1  = a;
    m_space1 = sp;
    for (int off = 0; off <= 2 + WS1; off++) begin
      if (off > 0) @(negedge clk);
      strobe = (off >= 1) && (off <= 1 + WS1);
      check("addr_bus",      int'(addr1), int'(a));
      check("memory_select", int'(ms1), int'(sp));
      check("read_en",       int'(rd1), int'(strobe && !wr));
      check("write_en",      int'(wr1), int'(strobe && wr));
      check("data_bus",      int'(data1), int'((strobe && wr) ? wd : keep1));
    end
  endtask

  initial begin
    begin : watchdog
      fork
        begin
          #200000;
          $display("FAIL watchdog: simulation time limit reached");
          $fatal(1, "time limit");
        end
      join_none
    end
  end

  initial begin
    bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_space = 1'b0;
    bus1.req_addr  = '0;   bus1.req_wdata = '0;
    bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_space = 1'b0;
    bus0.req_addr  = '0;   bus0.req_wdata = '0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", int'(bus1.req_ready), 1);
    check("rst_rsp_valid", int'(bus1.rsp_valid), 0);
    check("rst_rsp_err",   int'(bus1.rsp_err), 0);
    check("rst_rsp_rdata", int'(bus1.rsp_rdata), 0);
    check("rst_addr_bus",  int'(addr1), 0);
    check("rst_msel",      int'(ms1), 0);
    check("rst_read_en",   int'(rd1), 0);
    check("rst_write_en",  int'(wr1), 0);
    check("rst_data_bus",  int'(data1), int'(keep1));
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", int'(bus1.req_ready), 1);

    // read RAM 0x0042 -> 0x5A
    issue1(1'b0, SPACE_RAM, 16'h0042, 8'h00, 8'h5A, 1'b0);
    // write SFR 0x0090 <- 0xA5
    issue1(1'b1, SPACE_RAM, 16'h0090, 8'hA5, 8'h00, 1'b0);
    // rejected write to ROM 0x1234
    issue1(1'b1, SPACE_ROM, 16'h1234, 8'h66, 8'h00, 1'b0);
    @(negedge clk);
    check("after_err_read_en", int'(rd1), 0);
    // back-to-back reads, request held; second accepted in HOLD
    issue1(1'b0, SPACE_RAM, 16'h0010, 8'h00, 8'h11, 1'b1);
    issue1(1'b0, SPACE_RAM, 16'h0011, 8'h00, 8'h22, 1'b0);
    @(negedge clk);

    // reset in the first STROBE cycle abandons the access
    bus1.req_valid = 1'b1; bus1.req_write = 1'b0; bus1.req_space = SPACE_RAM;
    bus1.req_addr  = 16'h0050; keep1 = 8'h77;
    check("abort_ready", int'(bus1.req_ready), 1);
    @(negedge clk);
    bus1.req_valid = 1'b0;
    @(negedge clk);
    check("abort_strobe_on", int'(rd1), 1);
    reset = 1'b0;
    @(negedge clk);
    check("abort_read_en",  int'(rd1), 0);
    check("abort_write_en", int'(wr1), 0);
    check("abort_data_bus", int'(data1), int'(keep1));
    check("abort_no_rsp",   int'(bus1.rsp_valid), 0);
    reset = 1'b1;
    m_addr1 = '0; m_space1 = 1'b0; m_rdata1 = 8'h00;
    @(negedge clk);
    check("abort_ready_after",  int'(bus1.req_ready), 1);
    check("abort_rdata_reset",  int'(bus1.rsp_rdata), 0);
    repeat (3) @(negedge clk);

    // recovery read into the SFR window
    issue1(1'b0, SPACE_RAM, {8'h00, SFR_BASE}, 8'h00, 8'h99, 1'b0);
    @(negedge clk);

    // WAIT_STATES = 0: ROM read 0x0100 -> 0x3C
    begin
      exp_t e;
      bus0.req_valid = 1'b1; bus0.req_write = 1'b0; bus0.req_space = SPACE_ROM;
      bus0.req_addr  = 16'h0100; keep0 = 8'h3C;
      check("ws0_ready", int'(bus0.req_ready), 1);
      e.err = 1'b0; e.rdata = 8'h3C; e.cyc = cyc + 3;
      q0.push_back(e);
      @(negedge clk);
      bus0.req_valid = 1'b0;
      check("ws0_setup_read_en", int'(rd0), 0);
      check("ws0_setup_addr",    int'(addr0), 16'h0100);
      check("ws0_setup_msel",    int'(ms0), 0);
      @(negedge clk);
      check("ws0_strobe_read_en", int'(rd0), 1);
      check("ws0_strobe_msel",    int'(ms0), 0);
      @(negedge clk);
      check("ws0_hold_read_en",   int'(rd0), 0);
    end

    repeat (5) @(negedge clk);
    check("q1_drained", q1.size(), 0);
    check("q0_drained", q0.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
